// File: rtl/pll_reset_sequencer.sv
// Supervises NUM_PLLS PLLs: filters lock flags, retries lock timeouts, releases domain resets in stages.
// Optional per-channel masking is compiled in with `define RSEQ_CHANNEL_MASK_EN.
module pll_reset_sequencer #(
  parameter int NUM_PLLS      = 4,
  parameter int ARESET_CYCLES = 4,
  parameter int LOCK_FILTER   = 8,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STAGE_DELAY   = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                clk_100m_in,
  input  logic                rst_n,
  input  logic [NUM_PLLS-1:0] pll_locked,
`ifdef RSEQ_CHANNEL_MASK_EN
  input  logic [NUM_PLLS-1:0] chan_mask,
`endif
  output logic [NUM_PLLS-1:0] pll_areset,
  output logic [NUM_PLLS-1:0] domain_reset_n,
  output logic                locked,
  output logic                fault,
  output logic [3:0]          retry_count,
  output logic [NUM_PLLS-1:0] lock_status
);

  localparam int REL_LAST = STAGE_DELAY * NUM_PLLS;
  localparam int CNT_MAX0 = (LOCK_TIMEOUT > REL_LAST) ? LOCK_TIMEOUT : REL_LAST;
  localparam int CNT_MAX  = (CNT_MAX0 > ARESET_CYCLES) ? CNT_MAX0 : ARESET_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int FILT_W   = $clog2(LOCK_FILTER + 1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          retry_q, retry_d;
  logic [NUM_PLLS-1:0] areset_q, areset_d;
  logic [NUM_PLLS-1:0] drn_q, drn_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;
  logic [NUM_PLLS-1:0] sync1_q, sync2_q;
  logic [FILT_W-1:0]   filt_q [NUM_PLLS];
  logic [FILT_W-1:0]   filt_d [NUM_PLLS];
  logic [NUM_PLLS-1:0] ls_q, ls_d;
  logic [NUM_PLLS-1:0] mask_s;
  logic                lock_all_s;

`ifdef RSEQ_CHANNEL_MASK_EN
  logic [NUM_PLLS-1:0] mask_q;

  // The mask is quasi-static, so it is only captured while the PLLs are held in reset.
  always_ff @(posedge clk_100m_in) begin
    if (!rst_n) begin
      mask_q <= {NUM_PLLS{1'b0}};
    end else if (state_q == S_PLL_RESET) begin
      mask_q <= chan_mask;
    end else begin
      mask_q <= mask_q;
    end
  end

  assign mask_s = mask_q;
`else
  assign mask_s = {NUM_PLLS{1'b0}};
`endif

  // Lock filters restart from zero whenever the PLLs are being reset.
  always_comb begin
    for (int k = 0; k < NUM_PLLS; k++) begin
      filt_d[k] = filt_q[k];
      if (state_q == S_PLL_RESET) begin
        filt_d[k] = {FILT_W{1'b0}};
      end else if (!sync2_q[k]) begin
        filt_d[k] = {FILT_W{1'b0}};
      end else if (filt_q[k] != FILT_W'(LOCK_FILTER)) begin
        filt_d[k] = filt_q[k] + {{(FILT_W-1){1'b0}}, 1'b1};
      end else begin
        filt_d[k] = filt_q[k];
      end
      ls_d[k] = (filt_d[k] == FILT_W'(LOCK_FILTER)) & ~mask_s[k];
    end
  end

  assign lock_all_s = &(ls_q | mask_s);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    areset_d = areset_q;
    drn_d    = drn_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    case (state_q)
      S_PLL_RESET: begin
        areset_d = {NUM_PLLS{1'b1}};
        drn_d    = {NUM_PLLS{1'b0}};
        locked_d = 1'b0;
        if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = {CNT_W{1'b0}};
          areset_d = mask_s;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_WAIT_LOCK: begin
        if (lock_all_s) begin
          state_d = S_RELEASE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d  = retry_q + 4'd1;
          cnt_d    = {CNT_W{1'b0}};
          areset_d = {NUM_PLLS{1'b1}};
          if (retry_d == 4'(MAX_RETRIES)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = S_PLL_RESET;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RELEASE, S_RUN: begin
        if (!lock_all_s) begin
          // Lock loss drops every domain at once and restarts the whole sequence.
          state_d  = S_PLL_RESET;
          cnt_d    = {CNT_W{1'b0}};
          areset_d = {NUM_PLLS{1'b1}};
          drn_d    = {NUM_PLLS{1'b0}};
          locked_d = 1'b0;
        end else if (state_q == S_RUN) begin
          locked_d = 1'b1;
        end else if (cnt_q == CNT_W'(REL_LAST)) begin
          state_d  = S_RUN;
          cnt_d    = {CNT_W{1'b0}};
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          for (int k = 0; k < NUM_PLLS; k++) begin
            if (cnt_d == CNT_W'(STAGE_DELAY * (k + 1))) begin
              drn_d[k] = ~mask_s[k];
            end else begin
              drn_d[k] = drn_q[k];
            end
          end
        end
      end
      S_FAULT: begin
        areset_d = {NUM_PLLS{1'b1}};
        drn_d    = {NUM_PLLS{1'b0}};
        locked_d = 1'b0;
        fault_d  = 1'b1;
      end
      default: begin
        state_d  = S_PLL_RESET;
        cnt_d    = {CNT_W{1'b0}};
        areset_d = {NUM_PLLS{1'b1}};
        drn_d    = {NUM_PLLS{1'b0}};
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100m_in) begin
    if (!rst_n) begin
      state_q  <= S_PLL_RESET;
      cnt_q    <= {CNT_W{1'b0}};
      retry_q  <= 4'd0;
      areset_q <= {NUM_PLLS{1'b1}};
      drn_q    <= {NUM_PLLS{1'b0}};
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      sync1_q  <= {NUM_PLLS{1'b0}};
      sync2_q  <= {NUM_PLLS{1'b0}};
      ls_q     <= {NUM_PLLS{1'b0}};
      for (int k = 0; k < NUM_PLLS; k++) begin
        filt_q[k] <= {FILT_W{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      areset_q <= areset_d;
      drn_q    <= drn_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      sync1_q  <= pll_locked;
      sync2_q  <= sync1_q;
      ls_q     <= ls_d;
      for (int k = 0; k < NUM_PLLS; k++) begin
        filt_q[k] <= filt_d[k];
      end
    end
  end

  assign pll_areset     = areset_q;
  assign domain_reset_n = drn_q;
  assign locked         = locked_q;
  assign fault          = fault_q;
  assign retry_count    = retry_q;
  assign lock_status    = ls_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: each stimulus pushes the timed output changes it should cause; a monitor pops them.
// Build with `define RSEQ_CHANNEL_MASK_EN to add the channel-mask scenario.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pll_locked;
  logic [3:0] pll_areset, domain_reset_n, retry_count, lock_status;
  logic       locked, fault;
  logic [3:0] msk = 4'b0000;
`ifdef RSEQ_CHANNEL_MASK_EN
  logic [3:0] chan_mask = 4'b0000;
`endif

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_PLLS(4), .ARESET_CYCLES(4), .LOCK_FILTER(8),
    .LOCK_TIMEOUT(1000), .STAGE_DELAY(16), .MAX_RETRIES(3)
  ) dut (
    .clk_100m_in   (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
`ifdef RSEQ_CHANNEL_MASK_EN
    .chan_mask     (chan_mask),
`endif
    .pll_areset    (pll_areset),
    .domain_reset_n(domain_reset_n),
    .locked        (locked),
    .fault         (fault),
    .retry_count   (retry_count),
    .lock_status   (lock_status)
  );

  typedef struct {
    int          t;
    logic [17:0] v;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [3:0]  e_ar, e_dr, e_ls, e_rc;
  logic        e_f, e_lk;
  logic [17:0] last_exp, prev_snap, mon_cur;
  ev_t         mon_ev;
  bit          mon_en = 1'b0;
  bit          tog_en = 1'b0;
  int          tog_cnt = 0;
  int          r, a, l, g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [17:0] cur_exp();
    return {e_ar, e_dr, e_ls, e_rc, e_f, e_lk};
  endfunction

  task automatic push(input int t);
    ev_t ev;
    if (cur_exp() !== last_exp) begin
      ev.t = t;
      ev.v = cur_exp();
      exp_q.push_back(ev);
      last_exp = ev.v;
    end
  endtask

  // Every change of the observed outputs must match the next scheduled event.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {pll_areset, domain_reset_n, lock_status, retry_count, fault, locked};
      if (mon_cur !== prev_snap) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_change", 32'(mon_cur), 32'(prev_snap));
        end else begin
          mon_ev = exp_q.pop_front();
          check_val("event_cycle", cyc, mon_ev.t);
          check_val("event_value", 32'(mon_cur), 32'(mon_ev.v));
        end
        prev_snap = mon_cur;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt == 5) begin
        pll_locked[0] = ~pll_locked[0];
        tog_cnt = 0;
      end
    end
  endtask

  task automatic to_cyc(input int x);
    while (cyc < x) step();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Pulse rst_n for one edge; returns the reset edge cycle and schedules the areset release.
  task automatic do_reset(output int rr);
    rst_n = 1'b0;
    e_ar = 4'hF; e_dr = 4'h0; e_ls = 4'h0; e_rc = 4'h0; e_f = 1'b0; e_lk = 1'b0;
    push(cyc + 1);
    step();
    rst_n = 1'b1;
    rr = cyc;
    e_ar = msk;
    push(rr + 4);
  endtask

  task automatic exp_release(input int rel, input int n);
    for (int k = 0; k < n; k++) begin
      e_dr[k] = ~msk[k];
      push(rel + 16 * (k + 1));
    end
    if (n == 4) begin
      e_lk = 1'b1;
      push(rel + 65);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pll_locked = 4'h0;
    repeat (3) step();
    check_val("rst_areset", 32'(pll_areset), 32'h0000000F);
    check_val("rst_drn", 32'(domain_reset_n), 32'h00000000);
    check_val("rst_locked", 32'(locked), 32'h00000000);
    check_val("rst_fault", 32'(fault), 32'h00000000);
    check_val("rst_retry", 32'(retry_count), 32'h00000000);
    check_val("rst_lock_status", 32'(lock_status), 32'h00000000);
    e_ar = 4'hF; e_dr = 4'h0; e_ls = 4'h0; e_rc = 4'h0; e_f = 1'b0; e_lk = 1'b0;
    last_exp = cur_exp();
    prev_snap = cur_exp();
    mon_en = 1'b1;

    // Clean bring-up: locks arrive 20 cycles after areset drops.
    rst_n = 1'b1;
    r = cyc;
    a = r + 4;
    e_ar = 4'h0;
    push(a);
    to_cyc(a + 20);
    pll_locked = 4'hF;
    e_ls = 4'hF;
    push(a + 30);
    exp_release(a + 31, 4);
    drain("bringup", 200);
    check_val("bringup_locked", 32'(locked), 32'h00000001);
    check_val("bringup_retry", 32'(retry_count), 32'h00000000);

    // One-cycle lock glitch in RUN forces a full re-sequence.
    repeat (5) step();
    g = cyc;
    pll_locked[1] = 1'b0;
    e_ls = 4'b1101;
    push(g + 3);
    e_dr = 4'h0; e_lk = 1'b0; e_ar = 4'hF;
    push(g + 4);
    e_ls = 4'h0;
    push(g + 5);
    e_ar = 4'h0;
    push(g + 8);
    e_ls = 4'hF;
    push(g + 16);
    exp_release(g + 17, 4);
    step();
    pll_locked[1] = 1'b1;
    drain("glitch", 200);
    check_val("glitch_retry", 32'(retry_count), 32'h00000000);

    // Reset pulse after two domains have been released.
    do_reset(r);
    e_ls = 4'hF;
    push(r + 12);
    l = r + 13;
    exp_release(l, 2);
    to_cyc(l + 40);
    check_val("midrel_drn", 32'(domain_reset_n), 32'h00000003);
    do_reset(r);
    check_val("midrel_reset_edge", r, l + 41);
    e_ls = 4'hF;
    push(r + 12);
    exp_release(r + 13, 4);
    drain("midrel", 300);

    // Channel 0 toggling with period 10 never passes the filter, so the attempt times out.
    pll_locked = 4'hE;
    tog_cnt = 0;
    tog_en = 1'b1;
    do_reset(r);
    e_ls = 4'hE;
    push(r + 12);
    a = r + 1004;
    e_rc = 4'd1; e_ar = 4'hF;
    push(a);
    e_ls = 4'h0;
    push(a + 1);
    e_ar = 4'h0;
    push(a + 4);
    e_ls = 4'hE;
    push(a + 12);
    drain("toggle", 1200);
    tog_en = 1'b0;
    check_val("toggle_ls0", 32'(lock_status[0]), 32'h00000000);

    // Channel 2 never locks: three timeouts end in a sticky fault.
    pll_locked = 4'b1011;
    do_reset(r);
    a = r + 4;
    for (int i = 1; i <= 3; i++) begin
      e_ls = 4'b1011;
      push(a + 8);
      e_rc = 4'(i); e_ar = 4'hF;
      if (i == 3) e_f = 1'b1;
      push(a + 1000);
      if (i < 3) begin
        e_ls = 4'h0;
        push(a + 1001);
        e_ar = 4'h0;
        push(a + 1004);
      end
      a = a + 1004;
    end
    drain("timeout", 3300);
    repeat (60) step();
    check_val("fault_sticky", 32'(fault), 32'h00000001);
    check_val("fault_areset", 32'(pll_areset), 32'h0000000F);
    check_val("fault_drn", 32'(domain_reset_n), 32'h00000000);
    check_val("fault_retry", 32'(retry_count), 32'h00000003);
    do_reset(r);
    e_ls = 4'b1011;
    push(r + 12);
    drain("fault_clear", 40);
    check_val("fault_cleared", 32'(fault), 32'h00000000);

`ifdef RSEQ_CHANNEL_MASK_EN
    // Channel 3 masked and never locks; the others still release on their usual slots.
    msk = 4'b1000;
    chan_mask = 4'b1000;
    pll_locked = 4'b0111;
    do_reset(r);
    e_ls = 4'b0111;
    push(r + 12);
    exp_release(r + 13, 4);
    drain("mask", 300);
    check_val("mask_drn", 32'(domain_reset_n), 32'h00000007);
    check_val("mask_areset", 32'(pll_areset), 32'h00000008);
    check_val("mask_locked", 32'(locked), 32'h00000001);
    check_val("mask_retry", 32'(retry_count), 32'h00000000);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
